// File: rtl/vram_scan_arbiter.sv
// Arbitrates the single-port playfield cell RAM between VGA scanout fetches and the game-logic client.
// Optional build macro VRAM_BLANK_ONLY_EN restricts CPU grants to vertical blanking.
module vram_scan_arbiter #(
  parameter int COLS      = 40,
  parameter int ROWS      = 30,
  parameter int CELL_BITS = 4,
  parameter int H_START   = 144,
  parameter int V_START   = 35,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pix_en_i,
  input  logic [15:0]       h_value_i,
  input  logic [15:0]       v_value_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] cell_type_o,
  output logic              cell_valid_o,
  output logic              underrun_o
);

  localparam int CELL_PX = 1 << CELL_BITS;
  localparam logic [15:0] SPAN    = 16'(COLS * CELL_PX);
  localparam logic [15:0] H_FETCH = 16'(H_START - CELL_PX);
  localparam logic [15:0] H_FIRST = 16'(H_START);
  localparam logic [15:0] H_END   = 16'(H_START + COLS * CELL_PX);
  localparam logic [15:0] V_FIRST = 16'(V_START);
  localparam logic [15:0] V_END   = 16'(V_START + ROWS * CELL_PX);
  localparam logic [15:0] COLS16  = 16'(COLS);

  typedef enum logic [2:0] {IDLE, DISP_ADDR, DISP_DATA, CPU_ADDR, CPU_DATA} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ramAddr_q, ramAddr_d;
  logic                ramWe_q, ramWe_d;
  logic [DATA_W-1:0]   ramWdata_q, ramWdata_d;
  logic [DATA_W-1:0]   cpuRdata_q;
  logic                dispPending_q;
  logic [ADDR_W-1:0]   dispAddr_q;
  logic [DATA_W-1:0]   fetchBuf_q;
  logic                fetchFull_q;
  logic [DATA_W-1:0]   cellType_q;
  logic                cellValid_q;
  logic                underrun_q;

  logic [15:0]         vOff, hFetchOff, hLoadOff;
  logic                vActive, fetchHit, loadHit, lineEnd;
  logic [ADDR_W-1:0]   fetchAddr;
  logic                cpuGrantOk;
  logic                takeDisp;

  // Offsets wrap below the window start, so a single upper-bound compare covers both edges.
  assign vOff      = v_value_i - V_FIRST;
  assign hFetchOff = h_value_i - H_FETCH;
  assign hLoadOff  = h_value_i - H_FIRST;
  assign vActive   = (v_value_i >= V_FIRST) && (v_value_i < V_END);
  assign fetchHit  = pix_en_i && vActive && (hFetchOff < SPAN) &&
                     (hFetchOff[CELL_BITS-1:0] == '0);
  assign loadHit   = pix_en_i && vActive && (hLoadOff < SPAN) &&
                     (hLoadOff[CELL_BITS-1:0] == '0);
  assign lineEnd   = pix_en_i && (!vActive || (h_value_i == H_END));
  assign fetchAddr = ADDR_W'((vOff >> CELL_BITS) * COLS16 + (hFetchOff >> CELL_BITS));

`ifdef VRAM_BLANK_ONLY_EN
  assign cpuGrantOk = !vActive;
`else
  assign cpuGrantOk = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ramAddr_d  = ramAddr_q;
    ramWe_d    = 1'b0;
    ramWdata_d = ramWdata_q;
    takeDisp   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dispPending_q) begin
          state_d   = DISP_ADDR;
          ramAddr_d = dispAddr_q;
          takeDisp  = 1'b1;
        end else if (cpu_req_i && cpuGrantOk) begin
          state_d    = CPU_ADDR;
          ramAddr_d  = cpu_addr_i;
          ramWe_d    = cpu_we_i;
          ramWdata_d = cpu_wdata_i;
        end
      end
      DISP_ADDR: state_d = DISP_DATA;
      DISP_DATA: state_d = IDLE;
      CPU_ADDR:  state_d = ramWe_q ? IDLE : CPU_DATA;
      CPU_DATA:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ramAddr_q  <= '0;
      ramWe_q    <= 1'b0;
      ramWdata_q <= '0;
      cpuRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ramAddr_q  <= ramAddr_d;
      ramWe_q    <= ramWe_d;
      ramWdata_q <= ramWdata_d;
      if (state_q == CPU_DATA) cpuRdata_q <= ram_rdata_i;
    end
  end

  // A new trigger while the previous fetch is still unserved means that cell will be lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dispPending_q <= 1'b0;
      dispAddr_q    <= '0;
      fetchBuf_q    <= '0;
      fetchFull_q   <= 1'b0;
      cellType_q    <= '0;
      cellValid_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      if (fetchHit) begin
        dispPending_q <= 1'b1;
        dispAddr_q    <= fetchAddr;
        if (dispPending_q && !takeDisp) underrun_q <= 1'b1;
      end else if (takeDisp) begin
        dispPending_q <= 1'b0;
      end

      if (state_q == DISP_DATA) begin
        fetchBuf_q  <= ram_rdata_i;
        fetchFull_q <= 1'b1;
      end else if (loadHit) begin
        fetchFull_q <= 1'b0;
      end

      if (loadHit) begin
        cellValid_q <= 1'b1;
        if (fetchFull_q) begin
          cellType_q <= fetchBuf_q;
        end else begin
          cellType_q <= '0;
          underrun_q <= 1'b1;
        end
      end else if (lineEnd) begin
        cellType_q  <= '0;
        cellValid_q <= 1'b0;
      end
    end
  end

  // Read data is forwarded straight from the RAM in its valid cycle and held afterwards.
  assign cpu_ack_o    = (state_q == CPU_ADDR);
  assign cpu_rvalid_o = (state_q == CPU_DATA);
  assign cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : cpuRdata_q;
  assign ram_addr_o   = ramAddr_q;
  assign ram_we_o     = ramWe_q;
  assign ram_wdata_o  = ramWdata_q;
  assign cell_type_o  = cellType_q;
  assign cell_valid_o = cellValid_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Self-checking bench for vram_scan_arbiter: behavioural RAM, CPU access table, scanline driver and scoreboards.
// Adapts the grant checks when VRAM_BLANK_ONLY_EN is defined.
module tb_vram_scan_arbiter;

  localparam int COLS     = 40;
  localparam int ROWS     = 30;
  localparam int H_START  = 144;
  localparam int V_START  = 35;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixEn;
  logic [15:0] hValue, vValue;
  logic        cpuReq, cpuWe;
  logic [10:0] cpuAddr;
  logic [1:0]  cpuWdata;
  logic        cpuAck, cpuRvalid;
  logic [1:0]  cpuRdata;
  logic [10:0] ramAddr;
  logic        ramWe;
  logic [1:0]  ramWdata;
  logic [1:0]  ramRdata;
  logic [1:0]  cellType;
  logic        cellValid;
  logic        underrun;

  logic [1:0]  vram   [0:2047];
  logic [1:0]  shadow [0:2047];
  logic [1:0]  rdQ [$];
  logic [2:0]  cellQ [$];
  logic        cellMark = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [1:0]  wdata;
    logic [1:0]  expRdata;
  } cpuVec_t;

  cpuVec_t vecs [10];

  vram_scan_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pix_en_i     (pixEn),
    .h_value_i    (hValue),
    .v_value_i    (vValue),
    .cpu_req_i    (cpuReq),
    .cpu_we_i     (cpuWe),
    .cpu_addr_i   (cpuAddr),
    .cpu_wdata_i  (cpuWdata),
    .cpu_ack_o    (cpuAck),
    .cpu_rdata_o  (cpuRdata),
    .cpu_rvalid_o (cpuRvalid),
    .ram_addr_o   (ramAddr),
    .ram_we_o     (ramWe),
    .ram_wdata_o  (ramWdata),
    .ram_rdata_i  (ramRdata),
    .cell_type_o  (cellType),
    .cell_valid_o (cellValid),
    .underrun_o   (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWe) vram[ramAddr] <= ramWdata;
    ramRdata <= vram[ramAddr];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitAck(input int limit, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!cpuAck && lat < limit);
  endtask

  task automatic rvalidMonitor();
    logic [1:0] exp;
    forever begin
      @(negedge clk);
      if (cpuRvalid) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpected rvalid", 1, 0);
        end else begin
          exp = rdQ.pop_front();
          checkOutput("cpu_rdata", int'(cpuRdata), int'(exp));
        end
      end
    end
  endtask

  task automatic cellMonitor();
    logic       due;
    logic [2:0] exp;
    forever begin
      @(posedge clk);
      due = cellMark;
      @(negedge clk);
      if (due) begin
        if (cellQ.size() == 0) begin
          checkOutput("cell scoreboard empty", 1, 0);
        end else begin
          exp = cellQ.pop_front();
          checkOutput("cell_type", int'(cellType), int'(exp[1:0]));
          checkOutput("cell_valid", int'(cellValid), int'(exp[2]));
        end
      end
    end
  endtask

  task automatic applyStimulus(input cpuVec_t v);
    int lat;
    @(posedge clk); #1;
    cpuReq   = 1'b1;
    cpuWe    = v.we;
    cpuAddr  = v.addr;
    cpuWdata = v.wdata;
    if (v.we) shadow[v.addr] = v.wdata;
    else      rdQ.push_back(v.expRdata);
    waitAck(MAX_WAIT, lat);
    checkOutput("ack latency", lat, 1);
    checkOutput("ram_we at ack", int'(ramWe), int'(v.we));
    checkOutput("ram_addr at ack", int'(ramAddr), int'(v.addr));
    if (v.we) checkOutput("ram_wdata at ack", int'(ramWdata), int'(v.wdata));
    @(posedge clk); #1;
    cpuReq = 1'b0;
    @(negedge clk);
    checkOutput("rvalid at N+2", int'(cpuRvalid), int'(!v.we));
  endtask

  task automatic scanLine(input int v, input int hFrom, input int hTo, input bit markEn);
    int addr;
    for (int h = hFrom; h <= hTo; h++) begin
      @(posedge clk); #1;
      hValue = 16'(h);
      vValue = 16'(v);
      pixEn  = 1'b1;
      if (markEn && v >= V_START && v < V_START + ROWS * 16) begin
        if (h >= H_START && h < H_START + COLS * 16 && (h - H_START) % 16 == 0) begin
          addr = ((v - V_START) / 16) * COLS + (h - H_START) / 16;
          cellQ.push_back({1'b1, shadow[addr]});
          cellMark = 1'b1;
        end else if (h == H_START + COLS * 16) begin
          cellQ.push_back(3'b000);
          cellMark = 1'b1;
        end
      end
      @(posedge clk); #1;
      pixEn    = 1'b0;
      cellMark = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic cpuStream(input int count);
    int lat;
    int a;
    @(posedge clk); #1;
    cpuReq = 1'b1;
    cpuWe  = 1'b0;
    for (int i = 0; i < count; i++) begin
      a = (i * 37) % (COLS * ROWS);
      cpuAddr = 11'(a);
      rdQ.push_back(shadow[a]);
      waitAck(MAX_WAIT, lat);
      checkOutput("stream ack seen", int'(cpuAck), 1);
      checkOutput("stream ack latency bound", int'(lat <= 5), 1);
      checkOutput("stream ram_addr", int'(ramAddr), a);
      @(posedge clk); #1;
    end
    cpuReq = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    cpuVec_t pv;

    vecs[0] = '{we: 1'b1, addr: 11'd5,    wdata: 2'd2, expRdata: 2'd0};
    vecs[1] = '{we: 1'b0, addr: 11'd5,    wdata: 2'd0, expRdata: 2'd2};
    vecs[2] = '{we: 1'b1, addr: 11'd0,    wdata: 2'd3, expRdata: 2'd0};
    vecs[3] = '{we: 1'b1, addr: 11'd79,   wdata: 2'd1, expRdata: 2'd0};
    vecs[4] = '{we: 1'b0, addr: 11'd0,    wdata: 2'd0, expRdata: 2'd3};
    vecs[5] = '{we: 1'b0, addr: 11'd79,   wdata: 2'd0, expRdata: 2'd1};
    vecs[6] = '{we: 1'b1, addr: 11'd1199, wdata: 2'd2, expRdata: 2'd0};
    vecs[7] = '{we: 1'b0, addr: 11'd1199, wdata: 2'd0, expRdata: 2'd2};
    vecs[8] = '{we: 1'b1, addr: 11'd2047, wdata: 2'd1, expRdata: 2'd0};
    vecs[9] = '{we: 1'b0, addr: 11'd2047, wdata: 2'd0, expRdata: 2'd1};

    reset = 1'b1; pixEn = 1'b0; hValue = '0; vValue = '0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;

    fork
      rvalidMonitor();
      cellMonitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ram_addr", int'(ramAddr), 0);
    checkOutput("reset ram_we", int'(ramWe), 0);
    checkOutput("reset cpu_ack", int'(cpuAck), 0);
    checkOutput("reset cpu_rvalid", int'(cpuRvalid), 0);
    checkOutput("reset cell_valid", int'(cellValid), 0);
    checkOutput("reset underrun", int'(underrun), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] preloading playfield during vertical blank");
    for (int i = 0; i < COLS * ROWS; i++) begin
      pv = '{we: 1'b1, addr: 11'(i), wdata: 2'((i ^ (i >> 3)) & 3), expRdata: 2'd0};
      if (i == 0)  pv.wdata = 2'd3;
      if (i == 79) pv.wdata = 2'd1;
      applyStimulus(pv);
    end

    $display("[TB] CPU access table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] scanning active lines");
    scanLine(35, 120, 790, 1'b1);
    scanLine(51, 120, 790, 1'b1);
    scanLine(514, 120, 790, 1'b1);
    checkOutput("underrun after scan", int'(underrun), 0);

`ifdef VRAM_BLANK_ONLY_EN
    scanLine(100, 120, 790, 1'b1);
`else
    $display("[TB] back-to-back CPU reads during an active line");
    fork
      scanLine(100, 120, 790, 1'b1);
      cpuStream(300);
    join
`endif
    checkOutput("underrun after busy line", int'(underrun), 0);

    $display("[TB] request during active line");
    @(posedge clk); #1;
    vValue = 16'd100; hValue = 16'd300; pixEn = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 11'd5;
    rdQ.push_back(shadow[5]);
`ifdef VRAM_BLANK_ONLY_EN
    waitAck(40, lat);
    checkOutput("no grant in active line", int'(cpuAck), 0);
    @(posedge clk); #1;
    vValue = 16'd515;
    waitAck(MAX_WAIT, lat);
    checkOutput("grant in blank", int'(cpuAck), 1);
    checkOutput("blank grant latency", int'(lat <= 3), 1);
`else
    waitAck(MAX_WAIT, lat);
    checkOutput("active grant latency", lat, 1);
`endif
    @(posedge clk); #1;
    cpuReq = 1'b0;
    @(negedge clk);
    checkOutput("active read rvalid", int'(cpuRvalid), 1);

    $display("[TB] missed fetch raises underrun");
    scanLine(200, 140, 150, 1'b0);
    checkOutput("underrun set", int'(underrun), 1);
    checkOutput("underrun cell_type", int'(cellType), 0);

    $display("[TB] reset during a display fetch");
    @(posedge clk); #1;
    vValue = 16'd51; hValue = 16'd208; pixEn = 1'b1;
    @(posedge clk); #1;
    pixEn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("disp ram_addr", int'(ramAddr), 45);
    checkOutput("disp ram_we", int'(ramWe), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid-fetch reset ram_addr", int'(ramAddr), 0);
    checkOutput("mid-fetch reset ram_we", int'(ramWe), 0);
    checkOutput("mid-fetch reset ram_wdata", int'(ramWdata), 0);
    checkOutput("mid-fetch reset cpu_ack", int'(cpuAck), 0);
    checkOutput("mid-fetch reset cpu_rvalid", int'(cpuRvalid), 0);
    checkOutput("mid-fetch reset cpu_rdata", int'(cpuRdata), 0);
    checkOutput("mid-fetch reset cell_type", int'(cellType), 0);
    checkOutput("mid-fetch reset cell_valid", int'(cellValid), 0);
    checkOutput("mid-fetch reset underrun", int'(underrun), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    hValue = 16'd224; pixEn = 1'b1;
    @(posedge clk); #1;
    pixEn = 1'b0;
    @(negedge clk);
    checkOutput("abandoned fetch not delivered", int'(underrun), 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("read scoreboard drained", rdQ.size(), 0);
    checkOutput("cell scoreboard drained", cellQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
